// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller:
// FSM state encoding, CSR addresses and trap cause codes.
package trap_pkg;

  typedef logic [1:0] trap_state_t;

  localparam trap_state_t ST_IDLE    = 2'd0;
  localparam trap_state_t ST_ENTER   = 2'd1;
  localparam trap_state_t ST_HANDLER = 2'd2;
  localparam trap_state_t ST_RETURN  = 2'd3;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [3:0] CAUSE_INST_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL       = 4'd2;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bus bundle between the trap controller, the pc block, decode and execute.
// Handshake: exc_en is a level request held until pc redirects; mret_req is a
// one-cycle pulse; pc_trap_taken/pc_ret_taken are one-cycle redirect pulses
// that the pc block always accepts (no ready), and csr_rdata is combinational.
interface trap_ctrl_if;
  import trap_pkg::*;

  logic        exc_en;
  logic [3:0]  exc_code;
  logic [63:0] exc_val;
  logic [63:0] exc_pc;
  logic        mret_req;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        pc_trap_taken;
  logic [63:0] pc_trap;
  logic        pc_ret_taken;
  logic [63:0] pc_ret;
  logic        in_handler;

  modport master (
    output exc_en, exc_code, exc_val, exc_pc, mret_req,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, pc_trap_taken, pc_trap, pc_ret_taken, pc_ret, in_handler
  );

  modport slave (
    input  exc_en, exc_code, exc_val, exc_pc, mret_req,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, pc_trap_taken, pc_trap, pc_ret_taken, pc_ret, in_handler
  );

endinterface

// File: rtl/trap_csr_file.sv
// The five machine-mode trap CSRs: software writes, trap capture (which wins
// over software writes to mepc/mcause/mtval) and the combinational read mux.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [3:0]  cap_code_i,
  input  logic [63:0] cap_val_i,
  input  logic [63:0] cap_pc_i,
  input  logic        trap_we_block_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o
);

  localparam logic [63:0] ALIGN_MASK = ~64'd3;

  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic        trap_we;

  assign trap_we = we_i && !trap_we_block_i && !capture_i;

  always_comb begin
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    if (we_i) begin
      case (addr_i)
        CSR_MTVEC:    mtvec_d    = wdata_i & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = wdata_i;
        CSR_MEPC:     if (trap_we) mepc_d   = wdata_i & ALIGN_MASK;
        CSR_MCAUSE:   if (trap_we) mcause_d = wdata_i;
        CSR_MTVAL:    if (trap_we) mtval_d  = wdata_i;
        default:      ;
      endcase
    end
    if (capture_i) begin
      mepc_d   = cap_pc_i & ALIGN_MASK;
      mcause_d = {60'b0, cap_code_i};
      mtval_d  = cap_val_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
      mepc_q     <= 64'd0;
      mcause_q   <= 64'd0;
      mtval_q    <= 64'd0;
      mscratch_q <= 64'd0;
    end else begin
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
    end
  end

  always_comb begin
    rdata_o = 64'd0;
    case (addr_i)
      CSR_MTVEC:    rdata_o = mtvec_q;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_q;
      CSR_MCAUSE:   rdata_o = mcause_q;
      CSR_MTVAL:    rdata_o = mtval_q;
      default:      rdata_o = 64'd0;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences trap entry, handler and mret return,
// and drives the pc redirect requests purely from registered state.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET = 64'h100
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus,
  output trap_state_t state_o
);

  trap_state_t state_q, state_d;
  logic        capture;
  logic        illegal_mret;
  logic [3:0]  cap_code;
  logic [63:0] cap_val;
  logic [63:0] mtvec;
  logic [63:0] mepc;

  // An mret outside a handler is itself an illegal-instruction trap.
  assign illegal_mret = (state_q == ST_IDLE) && !bus.exc_en && bus.mret_req;
  assign capture      = ((state_q == ST_IDLE) && (bus.exc_en || bus.mret_req)) ||
                        ((state_q == ST_HANDLER) && bus.exc_en);
  assign cap_code     = illegal_mret ? CAUSE_ILLEGAL : bus.exc_code;
  assign cap_val      = illegal_mret ? 64'd0 : bus.exc_val;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (capture) state_d = ST_ENTER;
      ST_ENTER:   state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (bus.exc_en)        state_d = ST_ENTER;
        else if (bus.mret_req) state_d = ST_RETURN;
      end
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  trap_csr_file #(
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk             (clk),
    .rst             (rst),
    .capture_i       (capture),
    .cap_code_i      (cap_code),
    .cap_val_i       (cap_val),
    .cap_pc_i        (bus.exc_pc),
    .trap_we_block_i (state_q == ST_ENTER),
    .we_i            (bus.csr_we),
    .addr_i          (bus.csr_addr),
    .wdata_i         (bus.csr_wdata),
    .rdata_o         (bus.csr_rdata),
    .mtvec_o         (mtvec),
    .mepc_o          (mepc)
  );

  assign bus.pc_trap_taken = (state_q == ST_ENTER);
  assign bus.pc_ret_taken  = (state_q == ST_RETURN);
  assign bus.in_handler    = (state_q == ST_HANDLER);
  assign bus.pc_trap       = mtvec;
  assign bus.pc_ret        = mepc;
  assign state_o           = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the trap CSRs.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  trap_state_t dbg_state;
  int          checks = 0;
  int          errors = 0;

  trap_ctrl_if bus ();

  trap_ctrl #(.MTVEC_RESET(64'h100)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: where the core is in the trap life cycle plus CSR contents.
  localparam int M_IDLE = 0, M_ENTER = 1, M_HANDLER = 2, M_RETURN = 3;
  int          m_mode;
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;

  task automatic model_reset();
    m_mode = M_IDLE; m_mtvec = 64'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_step();
    bit takes_trap, bad_mret;
    takes_trap = (m_mode == M_IDLE && (bus.exc_en || bus.mret_req)) || (m_mode == M_HANDLER && bus.exc_en);
    bad_mret   = (m_mode == M_IDLE) && !bus.exc_en && bus.mret_req;
    if (bus.csr_we) begin
      if (bus.csr_addr == 12'h305) m_mtvec = bus.csr_wdata & ~64'd3;
      if (bus.csr_addr == 12'h340) m_mscratch = bus.csr_wdata;
      if (!takes_trap && m_mode != M_ENTER) begin
        if (bus.csr_addr == 12'h341) m_mepc = bus.csr_wdata & ~64'd3;
        if (bus.csr_addr == 12'h342) m_mcause = bus.csr_wdata;
        if (bus.csr_addr == 12'h343) m_mtval = bus.csr_wdata;
      end
    end
    if (takes_trap) begin
      m_mepc   = bus.exc_pc & ~64'd3;
      m_mcause = bad_mret ? 64'd2 : 64'(bus.exc_code);
      m_mtval  = bad_mret ? 64'd0 : bus.exc_val;
    end
    if (takes_trap)                              m_mode = M_ENTER;
    else if (m_mode == M_ENTER)                  m_mode = M_HANDLER;
    else if (m_mode == M_HANDLER && bus.mret_req) m_mode = M_RETURN;
    else if (m_mode == M_RETURN)                 m_mode = M_IDLE;
  endtask

  task automatic clear_inputs();
    bus.exc_en = 0; bus.exc_code = 0; bus.exc_val = 0; bus.exc_pc = 0; bus.mret_req = 0;
    bus.csr_we = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [63:0] d);
    bus.csr_addr = a;
    #1;
    d = bus.csr_rdata;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    read_csr(12'h305, d);
    checks++; if (d !== 64'h100) begin errors++; $display("FAIL reset_mtvec got %h exp %h", d, 64'h100); end
    read_csr(12'h341, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL reset_mepc got %h exp 0", d); end
    checks++; if ({bus.pc_trap_taken, bus.pc_ret_taken, bus.in_handler} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got %b exp 000", {bus.pc_trap_taken, bus.pc_ret_taken, bus.in_handler});
    end
    checks++; if (bus.pc_trap !== 64'h100 || bus.pc_ret !== 64'h0) begin
      errors++; $display("FAIL reset_targets got %h/%h exp 100/0", bus.pc_trap, bus.pc_ret);
    end
    bus.csr_addr = 0;
  endtask

  task automatic test_trap_entry();
    logic [63:0] d;
    bus.csr_we = 1; bus.csr_addr = 12'h305; bus.csr_wdata = 64'h2003;
    tick();
    clear_inputs();
    read_csr(12'h305, d);
    checks++; if (d !== 64'h2000) begin errors++; $display("FAIL mtvec_write got %h exp 2000", d); end
    bus.exc_en = 1; bus.exc_code = 0; bus.exc_val = 64'h1002; bus.exc_pc = 64'h1000;
    tick();
    clear_inputs();
    checks++; if (bus.pc_trap_taken !== 1'b1 || bus.pc_trap !== 64'h2000) begin
      errors++; $display("FAIL trap_redirect got %b/%h exp 1/2000", bus.pc_trap_taken, bus.pc_trap);
    end
    read_csr(12'h341, d);
    checks++; if (d !== 64'h1000) begin errors++; $display("FAIL trap_mepc got %h exp 1000", d); end
    read_csr(12'h342, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL trap_mcause got %h exp 0", d); end
    read_csr(12'h343, d);
    checks++; if (d !== 64'h1002) begin errors++; $display("FAIL trap_mtval got %h exp 1002", d); end
    bus.csr_addr = 0;
  endtask

  task automatic test_mret();
    tick();
    checks++; if (bus.in_handler !== 1'b1) begin errors++; $display("FAIL handler_flag got %b exp 1", bus.in_handler); end
    bus.mret_req = 1;
    tick();
    bus.mret_req = 0;
    checks++; if (bus.pc_ret_taken !== 1'b1 || bus.pc_ret !== 64'h1000 || bus.pc_trap_taken !== 1'b0) begin
      errors++; $display("FAIL mret_redirect got %b/%h exp 1/1000", bus.pc_ret_taken, bus.pc_ret);
    end
    tick();
    checks++; if (bus.in_handler !== 1'b0 || bus.pc_ret_taken !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL mret_idle got handler %b ret %b exp 0 0", bus.in_handler, bus.pc_ret_taken);
    end
  endtask

  task automatic test_held_exc();
    int pulses = 0;
    bus.exc_en = 1; bus.exc_pc = 64'h1800; bus.exc_code = 4'd0;
    tick();
    if (bus.pc_trap_taken) pulses++;
    tick();
    bus.exc_en = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.pc_trap_taken) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL held_exc_pulses got %0d exp 1", pulses); end
    checks++; if (bus.in_handler !== 1'b1) begin errors++; $display("FAIL held_exc_handler got %b exp 1", bus.in_handler); end
  endtask

  task automatic test_nested_priority();
    logic [63:0] d;
    bus.exc_en = 1; bus.mret_req = 1; bus.exc_code = 4'd5; bus.exc_val = 64'hbeef; bus.exc_pc = 64'h3007;
    tick();
    clear_inputs();
    checks++; if (bus.pc_trap_taken !== 1'b1 || bus.pc_ret_taken !== 1'b0) begin
      errors++; $display("FAIL nested_priority got trap %b ret %b exp 1 0", bus.pc_trap_taken, bus.pc_ret_taken);
    end
    read_csr(12'h341, d);
    checks++; if (d !== 64'h3004) begin errors++; $display("FAIL nested_mepc got %h exp 3004", d); end
    // A write to mepc during ENTER must not land.
    bus.csr_we = 1; bus.csr_addr = 12'h341; bus.csr_wdata = 64'h5555;
    tick();
    clear_inputs();
    read_csr(12'h341, d);
    checks++; if (d !== 64'h3004) begin errors++; $display("FAIL enter_write_block got %h exp 3004", d); end
    bus.mret_req = 1;
    tick();
    bus.mret_req = 0;
    tick();
  endtask

  task automatic test_illegal_mret();
    logic [63:0] d;
    bus.mret_req = 1; bus.exc_pc = 64'h40; bus.exc_code = 4'd7; bus.exc_val = 64'h77;
    tick();
    clear_inputs();
    checks++; if (bus.pc_trap_taken !== 1'b1) begin errors++; $display("FAIL illegal_trap got %b exp 1", bus.pc_trap_taken); end
    read_csr(12'h342, d);
    checks++; if (d !== 64'd2) begin errors++; $display("FAIL illegal_mcause got %h exp 2", d); end
    read_csr(12'h343, d);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL illegal_mtval got %h exp 0", d); end
    read_csr(12'h341, d);
    checks++; if (d !== 64'h40) begin errors++; $display("FAIL illegal_mepc got %h exp 40", d); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] d;
    // Currently in ENTER from the previous test.
    #2 rst = 1;
    #1;
    checks++; if (bus.pc_trap_taken !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL abort_enter got trap %b state %0d exp 0 0", bus.pc_trap_taken, dbg_state);
    end
    @(posedge clk); #1 rst = 0;
    model_reset();
    read_csr(12'h342, d);
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL abort_mcause got %h exp 0", d); end
    bus.exc_en = 1; tick(); bus.exc_en = 0; tick();
    bus.mret_req = 1; tick(); bus.mret_req = 0;
    checks++; if (bus.pc_ret_taken !== 1'b1) begin errors++; $display("FAIL pre_abort_ret got %b exp 1", bus.pc_ret_taken); end
    #2 rst = 1;
    #1;
    checks++; if (bus.pc_ret_taken !== 1'b0) begin errors++; $display("FAIL abort_return got %b exp 0", bus.pc_ret_taken); end
    @(posedge clk); #1 rst = 0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [11:0] addrs [6];
    addrs[0] = 12'h305; addrs[1] = 12'h340; addrs[2] = 12'h341;
    addrs[3] = 12'h342; addrs[4] = 12'h343; addrs[5] = 12'h300;
    for (int i = 0; i < 400; i++) begin
      bus.exc_en    = ($urandom_range(0, 5) == 0);
      bus.mret_req  = ($urandom_range(0, 4) == 0);
      bus.exc_code  = 4'($urandom_range(0, 15));
      bus.exc_val   = {$urandom, $urandom};
      bus.exc_pc    = {$urandom, $urandom};
      bus.csr_we    = ($urandom_range(0, 2) == 0);
      bus.csr_addr  = addrs[$urandom_range(0, 5)];
      bus.csr_wdata = {$urandom, $urandom};
      #1;
      checks++; if (bus.csr_rdata !== model_read(bus.csr_addr)) begin
        errors++; $display("FAIL rand_rdata cyc %0d addr %h got %h exp %h", i, bus.csr_addr, bus.csr_rdata, model_read(bus.csr_addr));
      end
      checks++; if (bus.pc_trap_taken !== (m_mode == M_ENTER) || bus.pc_ret_taken !== (m_mode == M_RETURN) ||
                    bus.in_handler !== (m_mode == M_HANDLER)) begin
        errors++; $display("FAIL rand_flags cyc %0d got t%b r%b h%b exp mode %0d", i, bus.pc_trap_taken, bus.pc_ret_taken, bus.in_handler, m_mode);
      end
      checks++; if (bus.pc_trap !== m_mtvec || bus.pc_ret !== m_mepc) begin
        errors++; $display("FAIL rand_targets cyc %0d got %h/%h exp %h/%h", i, bus.pc_trap, bus.pc_ret, m_mtvec, m_mepc);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_trap_entry();
    test_mret();
    test_held_exc();
    bus.mret_req = 1; tick(); bus.mret_req = 0; tick();
    test_illegal_mret();
    tick();
    test_nested_priority();
    bus.exc_en = 1; tick(); bus.exc_en = 0;
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
